// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM request arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int NUM_PORTS = 2;
    localparam int DEF_AW    = 20;
    localparam int DEF_DW    = 32;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// rtl/sram_arb_rr_pick.sv - combinational two-way round-robin picker
//
// Ports:
//   req[1:0]   request levels of port 1 / port 0
//   ptr        port favoured when both request
//   lock_hold  favoured port is currently retaining priority through a lock
//   gnt        winning port id
//   valid      at least one port requests
module sram_arb_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       lock_hold,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        // The favoured port wins under contention; a held lock only matters
        // while its owner is actually requesting, otherwise the idle owner
        // must not block the other port.
        if ((req == 2'b11) || (lock_hold && req[ptr])) begin
            gnt = ptr;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-port arbiter in front of the SRAM controller handshake
//
// Ports:
//   HCLK, HRESET                      clock, synchronous active-high reset
//   reqN/lockN/writeN/sizeN/addrN/wdataN  requester N transfer fields (held until ackN)
//   ackN, errN, rdataN                 completion pulse, timeout flag, read data of port N
//   ahbsram_req/write/size/addr/wdata  request to the SRAM controller
//   sramahb_ack, sramahb_rdata, BUSY   controller completion, read data, busy
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int MAX_LOCK       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          write0,
    input  logic          write1,
    input  logic [2:0]    size0,
    input  logic [2:0]    size1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          err0,
    output logic          err1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ahbsram_req,
    output logic          ahbsram_write,
    output logic [2:0]    ahbsram_size,
    output logic [AW-1:0] ahbsram_addr,
    output logic [DW-1:0] ahbsram_wdata,
    input  logic          sramahb_ack,
    input  logic [DW-1:0] sramahb_rdata,
    input  logic          BUSY
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam int LW = ($clog2(MAX_LOCK + 1) > 1) ? $clog2(MAX_LOCK + 1) : 1;

    arb_state_t           state, state_d;
    logic                 gnt_q, lock_q, write_q, err_q, ptr;
    logic [2:0]           size_q;
    logic [AW-1:0]        addr_q;
    logic [DW-1:0]        wdata_q, rdata0_q, rdata1_q;
    logic [TW-1:0]        tmo_cnt;
    logic [LW-1:0]        lock_cnt, lock_next;
    logic [NUM_PORTS-1:0] req_vec;
    logic                 pick_gnt, pick_valid, tmo_hit;

    assign req_vec = {req1, req0};

    sram_arb_rr_pick u_pick (
        .req       (req_vec),
        .ptr       (ptr),
        .lock_hold (lock_cnt != '0),
        .gnt       (pick_gnt),
        .valid     (pick_valid)
    );

    // Last WAIT cycle before giving up; a controller ack in the same cycle wins.
    assign tmo_hit = (state == ST_WAIT) && !sramahb_ack &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Locked streak length if this completion keeps priority; a grant that
    // landed on the non-favoured port starts a fresh streak.
    assign lock_next = (gnt_q == ptr) ? lock_cnt + LW'(1) : LW'(1);

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (pick_valid && !BUSY) state_d = ST_ISSUE;
            ST_ISSUE: state_d = sramahb_ack ? ST_DONE : ST_WAIT;
            ST_WAIT:  if (sramahb_ack || tmo_hit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            gnt_q    <= 1'b0;
            lock_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_cnt  <= '0;
            ptr      <= 1'b0;
            lock_cnt <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && state_d == ST_ISSUE) begin
                gnt_q   <= pick_gnt;
                lock_q  <= pick_gnt ? lock1  : lock0;
                write_q <= pick_gnt ? write1 : write0;
                size_q  <= pick_gnt ? size1  : size0;
                addr_q  <= pick_gnt ? addr1  : addr0;
                wdata_q <= pick_gnt ? wdata1 : wdata0;
                err_q   <= 1'b0;
                tmo_cnt <= '0;
            end
            if ((state == ST_ISSUE || state == ST_WAIT) && sramahb_ack) begin
                if (gnt_q) rdata1_q <= sramahb_rdata;
                else       rdata0_q <= sramahb_rdata;
            end
            if (state == ST_WAIT && !sramahb_ack) begin
                if (tmo_hit) err_q <= 1'b1;
                if (tmo_cnt != {TW{1'b1}}) tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (state == ST_DONE) begin
                if (lock_q && (int'(lock_next) < MAX_LOCK)) begin
                    ptr      <= gnt_q;
                    lock_cnt <= lock_next;
                end else begin
                    ptr      <= ~gnt_q;
                    lock_cnt <= '0;
                end
            end
        end
    end

    assign ahbsram_req   = (state == ST_ISSUE);
    assign ahbsram_write = write_q;
    assign ahbsram_size  = size_q;
    assign ahbsram_addr  = addr_q;
    assign ahbsram_wdata = wdata_q;

    assign ack0   = (state == ST_DONE) && !gnt_q;
    assign ack1   = (state == ST_DONE) &&  gnt_q;
    assign err0   = ack0 && err_q;
    assign err1   = ack1 && err_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        req0, req1, lock0, lock1, write0, write1;
    logic [2:0]  size0, size1;
    logic [19:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        ahbsram_req, ahbsram_write;
    logic [2:0]  ahbsram_size;
    logic [19:0] ahbsram_addr;
    logic [31:0] ahbsram_wdata;
    logic        sramahb_ack;
    logic [31:0] sramahb_rdata;
    logic        BUSY;

    always #5 HCLK = ~HCLK;

    sram_req_arbiter dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .write0(write0), .write1(write1), .size0(size0), .size1(size1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write),
        .ahbsram_size(ahbsram_size), .ahbsram_addr(ahbsram_addr),
        .ahbsram_wdata(ahbsram_wdata),
        .sramahb_ack(sramahb_ack), .sramahb_rdata(sramahb_rdata), .BUSY(BUSY)
    );

    typedef struct {
        logic        port;
        logic [19:0] addr;
        logic        write;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   issue_cnt = 0, issue_cyc = 0, ack_cyc = 0;
    int   ack_cnt = 0, ack0_cnt = 0, ack1_cnt = 0;
    logic [19:0] last_issue_addr = '0;
    int   rem0 = 0, rem1 = 0;
    int   ack_dly = 0;
    int   pend = 0;
    bit   stray = 0;
    bit   use_fixed = 0;
    logic [31:0] fixed_data = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] f_rd(input logic [19:0] a);
        return {12'hC0D, a};
    endfunction

    task automatic push(input logic p, input logic [19:0] a, input logic w,
                        input logic e, input logic [31:0] rd);
        exp_t x;
        x.port = p; x.addr = a; x.write = w; x.err = e; x.rdata = rd;
        sb.push_back(x);
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic drain(input int max);
        int i;
        i = 0;
        while (sb.size() != 0 && i < max) begin
            tick();
            i++;
        end
        check_val("drain", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (2) tick();
    endtask

    task automatic do_reset;
        tick();
        HRESET = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; write0 = 0; write1 = 0;
        rem0 = 0; rem1 = 0;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    always @(posedge HCLK) cyc++;

    // SRAM controller model: acks ack_dly cycles after the request pulse
    // (0 = in the issue cycle itself, negative = never).
    always @(posedge HCLK) begin
        #2;
        sramahb_ack = 1'b0;
        if (HRESET) begin
            pend = 0;
        end else begin
            if (stray) begin
                stray = 0;
                sramahb_ack = 1'b1;
                sramahb_rdata = 32'h5A5A5A5A;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sramahb_ack = 1'b1;
                    sramahb_rdata = use_fixed ? fixed_data : f_rd(ahbsram_addr);
                end
            end
            if (ahbsram_req && ack_dly >= 0) begin
                if (ack_dly == 0) begin
                    sramahb_ack = 1'b1;
                    sramahb_rdata = use_fixed ? fixed_data : f_rd(ahbsram_addr);
                end else begin
                    pend = ack_dly;
                end
            end
        end
    end

    // Requesters advance their address on ack and drop when out of work.
    always @(posedge HCLK) begin
        #1;
        if (ack0) begin
            addr0 = addr0 + 20'd4;
            if (rem0 > 0) rem0--;
            if (rem0 == 0) req0 = 1'b0;
        end
        if (ack1) begin
            addr1 = addr1 + 20'd4;
            if (rem1 > 0) rem1--;
            if (rem1 == 0) req1 = 1'b0;
        end
    end

    always @(negedge HCLK) begin
        exp_t e;
        if (ahbsram_req) begin
            issue_cnt++;
            issue_cyc = cyc;
            last_issue_addr = ahbsram_addr;
        end
        if (ack0 || ack1) begin
            ack_cnt++;
            ack_cyc = cyc;
            if (ack0) ack0_cnt++;
            if (ack1) ack1_cnt++;
            if (sb.size() == 0) begin
                check_val("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("grant_port", 32'(ack1), 32'(e.port));
                check_val("ack_exclusive", 32'(ack0 & ack1), 32'd0);
                check_val("addr", 32'(ahbsram_addr), 32'(e.addr));
                check_val("write", 32'(ahbsram_write), 32'(e.write));
                check_val("err", 32'(e.port ? err1 : err0), 32'(e.err));
                check_val("other_err", 32'(e.port ? err0 : err1), 32'd0);
                check_val("rdata", e.port ? rdata1 : rdata0, e.rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, a0, a1, c0, c1;
        int pat[10];
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        HRESET = 1; BUSY = 0; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
        write0 = 0; write1 = 0; size0 = HSIZE_WORD; size1 = HSIZE_HALF;
        addr0 = '0; addr1 = '0; wdata0 = 32'h11111111; wdata1 = 32'h22222222;
        sramahb_ack = 0; sramahb_rdata = '0;
        repeat (3) tick();
        HRESET = 0;
        @(negedge HCLK);
        check_val("rst_ack0", 32'(ack0), 0);
        check_val("rst_ack1", 32'(ack1), 0);
        check_val("rst_err0", 32'(err0), 0);
        check_val("rst_err1", 32'(err1), 0);
        check_val("rst_req", 32'(ahbsram_req), 0);
        check_val("rst_addr", 32'(ahbsram_addr), 0);
        check_val("rst_rdata0", rdata0, 0);
        check_val("rst_rdata1", rdata1, 0);

        // single read with 2-cycle controller latency
        do_reset();
        ack_dly = 2; use_fixed = 1; fixed_data = 32'hDEADBEEF;
        n = issue_cnt;
        push(0, 20'h00010, 0, 0, 32'hDEADBEEF);
        addr0 = 20'h00010; rem0 = 1; req0 = 1;
        drain(50);
        check_val("single_issues", 32'(issue_cnt - n), 32'd1);
        check_val("single_issue_addr", 32'(last_issue_addr), 32'h10);
        use_fixed = 0;

        // contention, no lock, immediate acks
        do_reset();
        ack_dly = 0; c0 = ack0_cnt; c1 = ack1_cnt;
        a0 = 'h100; a1 = 'h200;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin push(0, 20'(a0), 0, 0, f_rd(20'(a0))); a0 += 4; end
            else            begin push(1, 20'(a1), 0, 0, f_rd(20'(a1))); a1 += 4; end
        end
        addr0 = 20'h100; addr1 = 20'h200; rem0 = 4; rem1 = 4; req0 = 1; req1 = 1;
        drain(200);
        check_val("contend_port0", 32'(ack0_cnt - c0), 32'd4);
        check_val("contend_port1", 32'(ack1_cnt - c1), 32'd4);

        // lock starvation bound
        do_reset();
        ack_dly = 0;
        a0 = 'h100; a1 = 'h200;
        for (int i = 0; i < 10; i++) begin
            if (pat[i] == 0) begin push(0, 20'(a0), 0, 0, f_rd(20'(a0))); a0 += 4; end
            else             begin push(1, 20'(a1), 0, 0, f_rd(20'(a1))); a1 += 4; end
        end
        addr0 = 20'h100; addr1 = 20'h200; rem0 = 8; rem1 = 2;
        lock0 = 1; req0 = 1; req1 = 1;
        drain(300);
        lock0 = 0;

        // BUSY gating
        do_reset();
        ack_dly = 1; BUSY = 1;
        n = issue_cnt;
        push(1, 20'h00300, 0, 0, f_rd(20'h00300));
        addr1 = 20'h00300; rem1 = 1; req1 = 1;
        repeat (10) tick();
        check_val("busy_no_issue", 32'(issue_cnt - n), 32'd0);
        BUSY = 0;
        @(negedge HCLK);
        check_val("busy_fall_cycle_req", 32'(ahbsram_req), 32'd0);
        @(negedge HCLK);
        check_val("busy_next_cycle_req", 32'(ahbsram_req), 32'd1);
        drain(50);

        // timeout on a write, then normal service
        do_reset();
        ack_dly = 0;
        push(1, 20'h00404, 0, 0, f_rd(20'h00404));
        addr1 = 20'h00404; rem1 = 1; req1 = 1;
        drain(50);
        ack_dly = -1;
        push(1, 20'h00400, 1, 1, f_rd(20'h00404));
        write1 = 1; size1 = HSIZE_BYTE; addr1 = 20'h00400; rem1 = 1; req1 = 1;
        drain(150);
        check_val("timeout_latency", 32'(ack_cyc - issue_cyc), 32'd65);
        write1 = 0; size1 = HSIZE_HALF; ack_dly = 1;
        push(1, 20'h00408, 0, 0, f_rd(20'h00408));
        addr1 = 20'h00408; rem1 = 1; req1 = 1;
        drain(50);

        // reset in WAIT, stray ack, pointer back to port 0
        do_reset();
        ack_dly = 0;
        push(0, 20'h00504, 0, 0, f_rd(20'h00504));
        addr0 = 20'h00504; rem0 = 1; req0 = 1;
        drain(50);
        ack_dly = -1; n = issue_cnt;
        addr0 = 20'h00500; rem0 = 1; req0 = 1;
        for (int i = 0; i < 20 && issue_cnt == n; i++) tick();
        check_val("midwait_issued", 32'(issue_cnt - n), 32'd1);
        repeat (5) tick();
        HRESET = 1; req0 = 0; rem0 = 0;
        tick();
        HRESET = 0;
        @(negedge HCLK);
        check_val("mrst_ack0", 32'(ack0), 0);
        check_val("mrst_err0", 32'(err0), 0);
        check_val("mrst_req", 32'(ahbsram_req), 0);
        check_val("mrst_rdata0", rdata0, 0);
        n = ack_cnt; c0 = issue_cnt;
        ack_dly = 0; stray = 1;
        repeat (4) tick();
        check_val("stray_no_ack", 32'(ack_cnt - n), 32'd0);
        check_val("stray_no_issue", 32'(issue_cnt - c0), 32'd0);
        push(0, 20'h00600, 0, 0, f_rd(20'h00600));
        push(1, 20'h00700, 0, 0, f_rd(20'h00700));
        addr0 = 20'h00600; addr1 = 20'h00700; rem0 = 1; rem1 = 1; req0 = 1; req1 = 1;
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
